// File: rtl/led_pattern_sequencer_pkg.sv
// Shared encodings and the direction rule for the LED pattern sequencer.
// Pure declarations, no state.
package led_pattern_sequencer_pkg;

  localparam logic [1:0] MODE_HOLD   = 2'b00;
  localparam logic [1:0] MODE_FWD    = 2'b01;
  localparam logic [1:0] MODE_REV    = 2'b10;
  localparam logic [1:0] MODE_BOUNCE = 2'b11;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam int POS_MAX_DEFAULT = 4;

  // Bounce turns around only at the end it is heading towards; HOLD keeps dir.
  function automatic logic pick_dir(input logic [1:0] mode, input logic [2:0] pos,
                                    input logic [2:0] pos_max, input logic dir);
    logic d;
    d = dir;
    case (mode)
      MODE_FWD: d = 1'b1;
      MODE_REV: d = 1'b0;
      MODE_BOUNCE: begin
        if (pos == pos_max && dir) d = 1'b0;
        else if (pos == 3'd0 && !dir) d = 1'b1;
      end
      default: d = dir;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/led_pattern_sequencer_step_prescaler.sv
// Step prescaler: tick every (TICK_DIV >> speed) enabled cycles, combinational from the count.
// Clears while disabled; a speed change that leaves the count past the new period ticks at once.
module led_pattern_sequencer_step_prescaler
  import led_pattern_sequencer_pkg::*;
#(
  parameter int TICK_DIV = 50000000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic [1:0] i_speed,
  output logic       o_tick
);

  localparam int CW = $clog2(TICK_DIV + 1);
  localparam logic [CW-1:0] DIV = CW'(TICK_DIV);

  logic [CW-1:0] r_count;
  logic [CW-1:0] w_last;

  assign w_last = (DIV >> i_speed) - CW'(1);
  assign o_tick = i_en && (r_count >= w_last);

  always_ff @(posedge i_clk) begin
    if (i_rst || !i_en || o_tick) r_count <= '0;
    else                          r_count <= r_count + CW'(1);
  end

endmodule

// File: rtl/led_pattern_sequencer.sv
// Drives step/w for the 5-position pattern FSM from a prescaler (RUN) or a button (IDLE).
// Every output is registered one cycle after its request; no backpressure from the pattern FSM.
module led_pattern_sequencer
  import led_pattern_sequencer_pkg::*;
#(
  parameter int TICK_DIV = 50000000,
  parameter int POS_MAX  = POS_MAX_DEFAULT
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_run,
  input  logic [1:0] i_mode,
  input  logic [1:0] i_speed,
  input  logic       i_step_btn,
  input  logic [2:0] i_pos,
  output logic       o_step,
  output logic       o_w,
  output logic       o_pattern_rst,
  output logic       o_dir
);

  localparam logic [2:0] POS_MAX_L = 3'(POS_MAX);

  logic [0:0] r_state;
  logic       r_btn_prev;
  logic       r_step;
  logic       r_w;
  logic       r_pattern_rst;
  logic       r_dir;

  logic w_en;
  logic w_tick;
  logic w_btn_edge;
  logic w_req;
  logic w_illegal;
  logic w_d;

  // Gating with i_run clears the count on the same edge that leaves RUN.
  assign w_en = (r_state == ST_RUN) && i_run;

  led_pattern_sequencer_step_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (w_en),
    .i_speed(i_speed),
    .o_tick (w_tick)
  );

  assign w_btn_edge = i_step_btn && !r_btn_prev;
  assign w_req      = (r_state == ST_RUN) ? (w_tick && (i_mode != MODE_HOLD))
                                          : (w_btn_edge && !i_run);
  assign w_illegal  = i_pos > POS_MAX_L;
  assign w_d        = pick_dir(i_mode, i_pos, POS_MAX_L, r_dir);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_btn_prev    <= 1'b0;
      r_step        <= 1'b0;
      r_w           <= 1'b1;
      r_pattern_rst <= 1'b0;
      r_dir         <= 1'b1;
    end else begin
      r_btn_prev <= i_step_btn;
      case (r_state)
        ST_IDLE: if (i_run)  r_state <= ST_RUN;
        default: if (!i_run) r_state <= ST_IDLE;
      endcase
      r_step        <= w_req && !w_illegal;
      r_pattern_rst <= w_req && w_illegal;
      if (w_req) begin
        if (w_illegal) begin
          r_dir <= 1'b1;
        end else begin
          r_w   <= w_d;
          r_dir <= w_d;
        end
      end
    end
  end

  assign o_step        = r_step;
  assign o_w           = r_w;
  assign o_pattern_rst = r_pattern_rst;
  assign o_dir         = r_dir;

endmodule
